// File: rtl/reg_alu_seq.sv
// Multi-cycle sequencer driving the reg_alu control/address/data bundle from a host-loaded program memory.
// Optional single-step mode (step input, STALL state) is built when SINGLE_STEP_EN is defined.
module reg_alu_seq #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = 5
) (
  input  logic            clk,
  input  logic            reset,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [15:0]     load_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [15:0]     instr_count,
  output logic            slt_sel,
  output logic            sel,
  output logic            main_sel,
  output logic            sft_sel,
  output logic            ryt_sft_sel,
  output logic            wr,
  output logic [1:0]      op,
  output logic [3:0]      sft_op,
  output logic [2:0]      rd_addr_a,
  output logic [2:0]      rd_addr_b,
  output logic [2:0]      wr_addr,
  output logic [15:0]     d_in
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ALU  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [PC_W:0] PC_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EXEC
`ifdef SINGLE_STEP_EN
    , S_STALL
`endif
  } state_t;

  state_t          state;
  logic [15:0]     imem [IMEM_DEPTH];
  logic [15:0]     rdata;
  logic [15:0]     ir;
  logic [PC_W:0]   pc;   // extra MSB flags a walk past the last word
  logic [15:0]     word;
  logic [15:0]     imm;
  logic [2:0]      opc;
  logic            load_bundle;
  logic            nb_slt, nb_sel, nb_main, nb_sft, nb_ryt, nb_wr;
  logic [1:0]      nb_op;
  logic [3:0]      nb_sft_op;
  logic [15:0]     nb_d_in;

  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && load_en)
      imem[load_addr] <= load_data;
    rdata <= imem[pc[PC_W-1:0]];
  end

  assign word = (state == S_IMM) ? ir : rdata;
  assign opc  = word[15:13];
  assign imm  = pc[PC_W] ? 16'h0000 : imem[pc[PC_W-1:0]];
  assign load_bundle = (state == S_IMM) ||
                       (state == S_DECODE && opc != OP_HALT && opc != OP_LDI);

  always_comb begin
    nb_slt    = 1'b0;
    nb_sel    = 1'b0;
    nb_main   = 1'b0;
    nb_sft    = 1'b0;
    nb_ryt    = 1'b0;
    nb_wr     = (opc != OP_NOP);
    nb_op     = 2'b00;
    nb_sft_op = 4'h0;
    nb_d_in   = 16'h0000;
    case (opc)
      OP_LDI: begin nb_main = 1'b1; nb_d_in = imm; end
      OP_ALU: begin nb_sel = 1'b1; nb_op = word[1:0]; end
      OP_SHL: begin nb_sel = 1'b1; nb_main = 1'b1; nb_sft_op = word[3:0]; end
      OP_SHR: begin nb_sel = 1'b1; nb_main = 1'b1; nb_sft = 1'b1; nb_sft_op = word[3:0]; end
      OP_SRA: begin
        nb_sel = 1'b1; nb_main = 1'b1; nb_sft = 1'b1; nb_ryt = 1'b1;
        nb_sft_op = word[3:0];
      end
      OP_SLT: begin
        nb_slt = 1'b1; nb_sel = 1'b1; nb_sft = 1'b1; nb_ryt = 1'b1;
        nb_sft_op = word[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= 16'h0000;
      instr_count <= 16'h0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      slt_sel     <= 1'b0;
      sel         <= 1'b0;
      main_sel    <= 1'b0;
      sft_sel     <= 1'b0;
      ryt_sft_sel <= 1'b0;
      wr          <= 1'b0;
      op          <= 2'b00;
      sft_op      <= 4'h0;
      rd_addr_a   <= 3'b000;
      rd_addr_b   <= 3'b000;
      wr_addr     <= 3'b000;
      d_in        <= 16'h0000;
    end else begin
      // bundle is live only for the single EXEC cycle that follows a load
      done        <= 1'b0;
      slt_sel     <= 1'b0;
      sel         <= 1'b0;
      main_sel    <= 1'b0;
      sft_sel     <= 1'b0;
      ryt_sft_sel <= 1'b0;
      wr          <= 1'b0;
      op          <= 2'b00;
      sft_op      <= 4'h0;
      rd_addr_a   <= 3'b000;
      rd_addr_b   <= 3'b000;
      wr_addr     <= 3'b000;
      d_in        <= 16'h0000;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            instr_count <= 16'h0000;
            busy        <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= rdata;
          pc <= pc + PC_ONE;
          if (opc == OP_HALT) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (opc == OP_LDI) begin
            state <= S_IMM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_IMM: begin
          pc    <= pc + PC_ONE;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (instr_count != 16'hFFFF)
            instr_count <= instr_count + 16'd1;
          if (pc[PC_W]) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
`ifdef SINGLE_STEP_EN
            state <= S_STALL;
`else
            state <= S_FETCH;
`endif
          end
        end
`ifdef SINGLE_STEP_EN
        S_STALL: if (step) state <= S_FETCH;
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (load_bundle) begin
        slt_sel     <= nb_slt;
        sel         <= nb_sel;
        main_sel    <= nb_main;
        sft_sel     <= nb_sft;
        ryt_sft_sel <= nb_ryt;
        wr          <= nb_wr;
        op          <= nb_op;
        sft_op      <= nb_sft_op;
        rd_addr_a   <= word[9:7];
        rd_addr_b   <= word[6:4];
        wr_addr     <= word[12:10];
        d_in        <= nb_d_in;
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench for reg_alu_seq: a program-level reference model predicts the bundle on every cycle.
module tb_reg_alu_seq;
  localparam int DEPTH = 32;
  localparam int PW    = 5;
`ifdef SINGLE_STEP_EN
  localparam int STALL_EXTRA = 1;
  logic step = 1'b1;
`else
  localparam int STALL_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0;
  logic [PW-1:0] load_addr = '0;
  logic [15:0] load_data = 16'h0000;
  logic start = 1'b0;
  logic busy, done, slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr;
  logic [15:0] instr_count, d_in;
  logic [1:0] op;
  logic [3:0] sft_op;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr;

  always #5 clk = ~clk;

  reg_alu_seq #(.IMEM_DEPTH(DEPTH), .PC_W(PW)) dut (
    .clk(clk), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .start(start),
    .busy(busy), .done(done), .instr_count(instr_count),
    .slt_sel(slt_sel), .sel(sel), .main_sel(main_sel), .sft_sel(sft_sel),
    .ryt_sft_sel(ryt_sft_sel), .wr(wr), .op(op), .sft_op(sft_op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in)
  );

  wire [36:0] dut_b = {slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr, op, sft_op,
                       rd_addr_a, rd_addr_b, wr_addr, d_in};

  int n_assert = 0;
  int n_fail = 0;
  logic [15:0] mem [DEPTH];
  logic [36:0] exp_b [512];
  int done_cycle;
  logic [15:0] exp_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bundle an instruction should present in its EXEC cycle, straight from the opcode table.
  function automatic logic [36:0] bundle_of(input logic [15:0] w, input logic [15:0] imm);
    logic s_slt, s_sel, s_main, s_sft, s_ryt;
    logic [1:0] o;
    logic [3:0] so;
    logic [15:0] d;
    {s_slt, s_sel, s_main, s_sft, s_ryt} = 5'b0;
    o = 2'b0; so = 4'h0; d = 16'h0;
    case (w[15:13])
      3'd1: begin s_main = 1; d = imm; end
      3'd2: begin s_sel = 1; o = w[1:0]; end
      3'd3: begin s_sel = 1; s_main = 1; so = w[3:0]; end
      3'd4: begin s_sel = 1; s_main = 1; s_sft = 1; so = w[3:0]; end
      3'd5: begin s_sel = 1; s_main = 1; s_sft = 1; s_ryt = 1; so = w[3:0]; end
      3'd6: begin s_slt = 1; s_sel = 1; s_sft = 1; s_ryt = 1; so = w[3:0]; end
      default: ;
    endcase
    return {s_slt, s_sel, s_main, s_sft, s_ryt, (w[15:13] != 3'd0), o, so,
            w[9:7], w[6:4], w[12:10], d};
  endfunction

  // Cycle 1 is the first cycle after the start edge; fills exp_b, done_cycle, exp_count.
  task automatic run_model();
    int pc, c, e;
    bit fin;
    logic [15:0] w, imm;
    for (int i = 0; i < 512; i++) exp_b[i] = '0;
    pc = 0; c = 1; fin = 0; exp_count = 0;
    for (int k = 0; k <= DEPTH && !fin; k++) begin
      w = mem[pc]; pc++;
      if (w[15:13] == 3'd7) begin
        done_cycle = c + 2; fin = 1;
      end else begin
        if (w[15:13] == 3'd1) begin
          imm = (pc < DEPTH) ? mem[pc] : 16'h0000;
          pc++; e = c + 3;
        end else begin
          imm = 16'h0000; e = c + 2;
        end
        exp_b[e] = bundle_of(w, imm);
        if (exp_count != 16'hFFFF) exp_count++;
        if (pc >= DEPTH) begin done_cycle = e + 1; fin = 1; end
        else c = e + 1 + STALL_EXTRA;
      end
    end
  endtask

  task automatic load_prog(input bit merge);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      load_en = 1; load_addr = PW'(i); load_data = mem[i];
      start = merge && (i == DEPTH - 1);
    end
    @(posedge clk); #1;
    load_en = 0; start = 0;
  endtask

  task automatic run_prog(input bit started, input bit poke, input int reset_at);
    run_model();
    if (!started) begin
      start = 1; @(posedge clk); #1; start = 0;
    end
    for (int c = 1; c <= done_cycle; c++) begin
      @(negedge clk);
      if (c == reset_at) begin
        reset = 1; @(posedge clk); #1; reset = 0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bundle", dut_b, 37'h0);
        check("rst_count", instr_count, 16'h0);
        return;
      end
      check($sformatf("bundle@%0d", c), dut_b, exp_b[c]);
      check($sformatf("busy@%0d", c), busy, (c < done_cycle));
      check($sformatf("done@%0d", c), done, (c == done_cycle));
      if (poke && c == 3) begin
        load_en = 1; load_addr = '0; load_data = 16'hFFFF; start = 1;
      end else if (poke && c == 4) begin
        load_en = 0; start = 0;
      end
    end
    check("count", instr_count, exp_count);
    repeat (3) @(negedge clk);
    check("count_hold", instr_count, exp_count);
    check("idle_busy", busy, 1'b0);
    check("idle_bundle", dut_b, 37'h0);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_bundle", dut_b, 37'h0);
    check("reset_count", instr_count, 16'h0);
    @(posedge clk); #1; reset = 0;

    // LDI r0,#03FF ; HALT
    fill(16'h0000);
    mem[0] = 16'h2000; mem[1] = 16'h03FF; mem[2] = 16'hE000;
    load_prog(0);
    run_prog(0, 0, 0);

    // LDI r0 ; SHL r1=r0<<3 ; HALT, last word loaded together with start
    fill(16'h0000);
    mem[0] = 16'h2000; mem[1] = 16'($urandom); mem[2] = 16'h6403; mem[3] = 16'hE000;
    load_prog(1);
    run_prog(1, 0, 0);

    // SHR, SRA, SLT
    fill(16'h0000);
    mem[0] = 16'h8403; mem[1] = 16'hA402; mem[2] = 16'hC1B0; mem[3] = 16'hE000;
    load_prog(0);
    run_prog(0, 0, 0);

    // all NOPs run off the end; then LDI in the last slot takes a zero immediate
    fill(16'h0000);
    load_prog(0);
    run_prog(0, 0, 0);
    mem[31] = 16'h2C00;
    load_prog(0);
    run_prog(0, 0, 0);

    // reset during IMM, then restart and poke load/start while busy
    fill(16'h0000);
    mem[0] = 16'h2000; mem[1] = 16'h03FF; mem[2] = 16'hE000;
    load_prog(0);
    run_prog(0, 0, 3);
    run_prog(0, 1, 0);
    run_prog(0, 0, 0);

    // random programs
    for (int p = 0; p < 4; p++) begin
      int halt_at;
      halt_at = $urandom_range(6, 40);
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = 16'($urandom);
        mem[i][15:13] = 3'($urandom_range(0, 6));
        if (i == halt_at) mem[i] = 16'hE000;
      end
      load_prog(0);
      run_prog(0, (p == 1), 0);
    end

`ifdef SINGLE_STEP_EN
    begin
      int wr_seen;
      bit got_done;
      logic [2:0] seen_addr;
      logic seen_ryt;
      fill(16'h0000);
      mem[0] = 16'h8403; mem[1] = 16'hA402; mem[2] = 16'hC1B0; mem[3] = 16'hE000;
      load_prog(0);
      step = 0;
      start = 1; @(posedge clk); #1; start = 0;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c >= 4) begin
          check("stall_busy", busy, 1'b1);
          check("stall_wr", wr, 1'b0);
        end
      end
      step = 1;
      wr_seen = 0; seen_addr = 3'd0; seen_ryt = 1'b0;
      for (int c = 15; c <= 24; c++) begin
        @(negedge clk);
        step = 0;
        if (wr) begin wr_seen++; seen_addr = wr_addr; seen_ryt = ryt_sft_sel; end
      end
      check("step_one_wr", 32'(wr_seen), 32'd1);
      check("step_wr_addr", seen_addr, 3'd1);
      check("step_ryt", seen_ryt, 1'b1);
      step = 1;
      got_done = 0;
      for (int k = 0; k < 40 && !got_done; k++) begin
        @(negedge clk);
        if (done) got_done = 1;
      end
      check("step_done", got_done, 1'b1);
      check("step_count", instr_count, 16'd3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of reg_alu and drives its complete control/address/data bundle.
- Holds a small program memory that the host loads while the block is idle.
- On start, fetches and decodes 16-bit instructions, then pulses the reg_alu write strobe once per instruction.
- Stops on HALT or at the end of memory and reports done plus a retired-instruction count.

Parameters:
IMEM_DEPTH, 32, program words; power of two, 4..256
PC_W, 5, program counter width; equals log2(IMEM_DEPTH)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high
load_en  in  1  write program word; honoured only in IDLE
load_addr  in  PC_W  program word address
load_data  in  16  program word
start  in  1  begin execution at pc=0; honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when execution ends
instr_count  out  16  instructions retired since last start; saturates at 16'hFFFF
slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr  out  1 each  reg_alu controls
op  out  2  reg_alu ALU op
sft_op  out  4  reg_alu shift amount
rd_addr_a, rd_addr_b, wr_addr  out  3 each  reg_alu addresses
d_in  out  16  reg_alu store data

Behaviour:
- Instruction format: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb, [3:0] imm4.
- Opcodes:
  - 000 NOP.
  - 001 LDI: the next word is the 16-bit immediate.
  - 010 ALU: op=imm4[1:0].
  - 011 SHL, 100 SHR (logical), 101 SRA: sft_op=imm4.
  - 110 SLT.
  - 111 HALT.
- FSM states: IDLE, FETCH, DECODE, IMM, EXEC.
  - IDLE -start-> FETCH, with pc=0 and instr_count=0.
  - FETCH: registered imem read at pc.
  - DECODE: ir latched, pc+1. If HALT: done pulse, go to IDLE. If LDI: go to IMM. Otherwise: go to EXEC.
  - IMM: immediate read at pc, pc+1, then go to EXEC.
  - EXEC: drive the bundle for one cycle, instr_count+1. Go to FETCH, or to IDLE with a done pulse if pc wrapped past IMEM_DEPTH-1.
- Per-instruction latency from FETCH entry to wr: 3 cycles for non-LDI, 4 cycles for LDI. NOP executes EXEC with wr=0 but still counts as retired.
- Bundle in EXEC:
  - rd_addr_a=ra, rd_addr_b=rb, wr_addr=rd, wr=1 (NOP: wr=0).
  - LDI: sel=0, main_sel=1, d_in=immediate, all other controls 0.
  - ALU: sel=1, main_sel=0, op=imm4[1:0].
  - SHL: sel=1, main_sel=1, sft_sel=0, ryt_sft_sel=0, sft_op=imm4.
  - SHR: same as SHL but sft_sel=1.
  - SRA: same as SHR but ryt_sft_sel=1.
  - SLT: slt_sel=1, sel=1, main_sel=0, sft_sel=1, ryt_sft_sel=1, sft_op=imm4.
  - d_in=0 for every opcode except LDI.
- Outside EXEC, every reg_alu output is 0. wr is never high for more than one consecutive cycle.
- Boundaries:
  - LDI at address IMEM_DEPTH-1: immediate taken as 16'h0000; the write happens, then done.
  - Execution ending by wrap (no HALT) raises done, same as HALT.
  - load_en or start outside IDLE is ignored; the program is unchanged.
  - load_en and start in the same IDLE cycle: the load is written first, and execution starts with the updated memory.
  - instr_count holds its value after done until the next start.
- Reset (any state, including mid-instruction):
  - Returns to IDLE; pc=0, ir=0, instr_count=0.
  - busy=0, done=0, all reg_alu outputs 0.
  - imem contents are not cleared.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state STALL.
  - After every EXEC (except when ending), the FSM goes to STALL. It leaves STALL for FETCH only on a cycle with step=1; busy stays 1 in STALL.
  - Reset from STALL goes to IDLE.
- Undefined: no step port, no STALL state; EXEC goes directly to FETCH.

Test Plan:
- Load 0:16'h2000, 1:16'h03FF, 2:16'hE000; pulse start -> exactly one wr pulse 4 cycles after FETCH entry, carrying wr_addr=0, d_in=16'h03FF, sel=0, main_sel=1. Then done pulses and instr_count=1.
- Program LDI r0, then 16'h6403 (SHL r1=r0<<3), then HALT -> second wr has wr_addr=1, rd_addr_a=0, sel=1, main_sel=1, sft_sel=0, sft_op=3. instr_count=2.
- Words 16'h8403 (SHR), 16'hA402 (SRA), 16'hC1B0 (SLT r0,r3,r3) -> control tuples (sft_sel, ryt_sft_sel) = (1,0), (1,1), and slt_sel=1 with main_sel=0 respectively.
- Fill all 32 words with NOP (16'h0000), start -> wr never asserted, done after 96 cycles, instr_count=32. LDI placed at address 31 -> d_in=0 on its write.
- Assert reset during IMM of an LDI -> next cycle busy=0, wr=0, instr_count=0. Restart -> program runs unchanged.
- load_en and start while busy -> ignored. With SINGLE_STEP_EN: the FSM holds in STALL until step=1, and one instruction executes per step.
